// File: rtl/button_conditioner.sv
// Button input stage: two-flop synchronizer, per-button debounce FSM, and a
// prioritized one-cycle key event so each physical press yields exactly one move.
module button_conditioner #(
  parameter int DB_COUNT = 250000,
  parameter int CNT_W    = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn_in,
  output logic [4:0]  db_level,
  output logic [4:0]  db_pulse,
  output logic        key_valid,
  output logic [2:0]  key_code,
  output logic        any_held,
  output logic [14:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMING    = 3'd1,
    S_PULSE     = 3'd2,
    S_HELD      = 3'd3,
    S_RELEASING = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic [4:0] sync1;
  logic [4:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // One independent debounce FSM per button; fsm_state packs them 3 bits each.
  for (genvar i = 0; i < 5; i++) begin : g_btn
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             pulse_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (sync2[i]) begin
              state_q <= S_ARMING;
              cnt_q   <= '0;
            end
          end
          S_ARMING: begin
            if (!sync2[i]) begin
              state_q <= S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_PULSE;
              level_q <= 1'b1;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PULSE: begin
            state_q <= S_HELD;
            pulse_q <= 1'b0;
          end
          S_HELD: begin
            if (!sync2[i]) begin
              state_q <= S_RELEASING;
              cnt_q   <= '0;
            end
          end
          S_RELEASING: begin
            if (sync2[i]) begin
              state_q <= S_HELD;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_IDLE;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
          end
        endcase
      end
    end

    assign db_level[i]         = level_q;
    assign db_pulse[i]         = pulse_q;
    assign fsm_state[3*i +: 3] = state_q;
  end

  // Center wins, then up/down/left/right; key_code is sticky between events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 3'd0;
    end else begin
      key_valid <= |db_pulse;
      if (db_pulse[4])      key_code <= 3'd4;
      else if (db_pulse[0]) key_code <= 3'd0;
      else if (db_pulse[1]) key_code <= 3'd1;
      else if (db_pulse[2]) key_code <= 3'd2;
      else if (db_pulse[3]) key_code <= 3'd3;
    end
  end

  assign any_held = |db_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_COUNT=4 (press/release after 7 edges).
module tb_button_conditioner;

  logic        clk;
  logic        rst;
  logic [4:0]  btn_in;
  logic [4:0]  db_level;
  logic [4:0]  db_pulse;
  logic        key_valid;
  logic [2:0]  key_code;
  logic        any_held;
  logic [14:0] fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int pc[5];
  int kv_cnt;
  int kv_code0_cnt;

  button_conditioner #(.DB_COUNT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .db_level(db_level), .db_pulse(db_pulse),
    .key_valid(key_valid), .key_code(key_code),
    .any_held(any_held), .fsm_state(fsm_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event monitor sampling on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) if (db_pulse[i]) pc[i]++;
      if (key_valid) begin
        kv_cnt++;
        if (key_code == 3'd0) kv_code0_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) pc[i] = 0;
    kv_cnt = 0;
    kv_code0_cnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    btn_in = 5'b0;
    clear_counts();
    tick(2);
    check("rst_level", 32'(db_level), 32'h0);
    check("rst_pulse", 32'(db_pulse), 32'h0);
    check("rst_kv", 32'(key_valid), 32'h0);
    check("rst_fsm", 32'(fsm_state), 32'h0);
    rst = 1'b0;
    tick(3);

    // Clean press on right
    clear_counts();
    btn_in[3] = 1'b1;
    tick(6);
    check("clean_pulse_e6", 32'(db_pulse[3]), 32'h0);
    check("clean_level_e6", 32'(db_level[3]), 32'h0);
    tick(1);
    check("clean_pulse_e7", 32'(db_pulse), 32'h08);
    check("clean_level_e7", 32'(db_level[3]), 32'h1);
    check("clean_kv_e7", 32'(key_valid), 32'h0);
    tick(1);
    check("clean_pulse_e8", 32'(db_pulse[3]), 32'h0);
    check("clean_kv_e8", 32'(key_valid), 32'h1);
    check("clean_code_e8", 32'(key_code), 32'h3);
    check("clean_any_held", 32'(any_held), 32'h1);
    tick(12);
    check("clean_hold_pulses", 32'(pc[3]), 32'd1);
    check("clean_hold_kv", 32'(kv_cnt), 32'd1);
    check("clean_code_sticky", 32'(key_code), 32'h3);
    btn_in[3] = 1'b0;
    tick(10);
    check("clean_release", 32'(db_level), 32'h0);
    check("clean_any_released", 32'(any_held), 32'h0);

    // Bounce on up: 3 high / 2 low, five times, then hold
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      btn_in[0] = 1'b1;
      tick(3);
      btn_in[0] = 1'b0;
      tick(2);
    end
    btn_in[0] = 1'b1;
    tick(6);
    check("bounce_no_pulse", 32'(pc[0]), 32'd0);
    check("bounce_level_e6", 32'(db_level[0]), 32'h0);
    tick(1);
    check("bounce_pulse_e7", 32'(db_pulse[0]), 32'h1);
    tick(10);
    check("bounce_one_pulse", 32'(pc[0]), 32'd1);
    btn_in[0] = 1'b0;
    tick(10);

    // Release glitch on left
    btn_in[2] = 1'b1;
    tick(12);
    clear_counts();
    btn_in[2] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      check("glitch_low_level", 32'(db_level[2]), 32'h1);
    end
    btn_in[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("glitch_high_level", 32'(db_level[2]), 32'h1);
    end
    btn_in[2] = 1'b0;
    tick(6);
    check("release_level_e6", 32'(db_level[2]), 32'h1);
    tick(1);
    check("release_level_e7", 32'(db_level[2]), 32'h0);
    check("glitch_no_pulse", 32'(pc[2]), 32'd0);
    tick(5);

    // Simultaneous center + down
    btn_in[4] = 1'b1;
    btn_in[1] = 1'b1;
    tick(7);
    check("simul_pulse", 32'(db_pulse), 32'h12);
    tick(1);
    check("simul_pulse_clear", 32'(db_pulse), 32'h00);
    check("simul_kv", 32'(key_valid), 32'h1);
    check("simul_code", 32'(key_code), 32'h4);
    btn_in[4] = 1'b0;
    tick(3);

    // Asynchronous reset while down is held
    #2 rst = 1'b1;
    #1;
    check("midrst_level", 32'(db_level), 32'h0);
    check("midrst_pulse", 32'(db_pulse), 32'h0);
    check("midrst_kv", 32'(key_valid), 32'h0);
    check("midrst_code", 32'(key_code), 32'h0);
    check("midrst_any", 32'(any_held), 32'h0);
    tick(2);
    rst = 1'b0;
    clear_counts();
    tick(6);
    check("rearm_pulse_e6", 32'(db_pulse[1]), 32'h0);
    tick(1);
    check("rearm_pulse_e7", 32'(db_pulse), 32'h02);
    check("rearm_level_e7", 32'(db_level[1]), 32'h1);
    tick(10);
    check("rearm_one_pulse", 32'(pc[1]), 32'd1);
    btn_in[1] = 1'b0;
    tick(10);

    // Three clean presses of up
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      btn_in[0] = 1'b1;
      tick(10);
      btn_in[0] = 1'b0;
      tick(10);
    end
    check("repeat_pulses", 32'(pc[0]), 32'd3);
    check("repeat_kv", 32'(kv_cnt), 32'd3);
    check("repeat_code0", 32'(kv_code0_cnt), 32'd3);
    check("repeat_idle", 32'(fsm_state), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream input stage for the tic-tac-toe cursor/board controller.
- Takes the raw board push-buttons (up, down, left, right, center) and synchronizes each one into clk.
- Debounces each button with its own state machine and produces a clean level, a single-cycle press pulse, and a prioritized one-cycle key event per physical press.
- The controller consumes db_pulse or key_valid/key_code, so one press moves the cursor exactly one cell regardless of bounce or hold duration.

Parameters:
- DB_COUNT, 250000: number of consecutive stable clk cycles required to accept a press or a release (10 ms at 25 MHz). Legal range is 1 to 2^CNT_W-1.
- CNT_W, 18: width of each per-button debounce counter.

Ports:
- clk  in  1  system clock (the controller's game clock domain)
- rst  in  1  reset
- btn_in  in  5  raw asynchronous buttons; bit0=up, bit1=down, bit2=left, bit3=right, bit4=center
- db_level  out  5  debounced button level, per bit
- db_pulse  out  5  one-cycle pulse on each accepted press, per bit
- key_valid  out  1  one-cycle flag; high when any db_pulse bit is high
- key_code  out  3  index of the highest-priority pulsing button; 0=up, 1=down, 2=left, 3=right, 4=center
- any_held  out  1  OR of db_level

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset state:
  - both synchronizer stages = 0
  - all FSMs in IDLE, all counters = 0
  - db_level = 0, db_pulse = 0, key_valid = 0, key_code = 0, any_held = 0
- Synchronizer: two flops per bit; the FSM sees sync2.
- Per-bit FSM, 5 states, registered state, Moore outputs:
  - IDLE: level 0.
    - sync2=1 -> ARMING, cnt <= 0.
  - ARMING: level 0.
    - sync2=0 -> IDLE.
    - else if cnt == DB_COUNT-1 -> PULSE.
    - else cnt <= cnt+1.
  - PULSE: level 1, pulse 1. Unconditionally -> HELD. Exactly one cycle.
  - HELD: level 1.
    - sync2=0 -> RELEASING, cnt <= 0.
  - RELEASING: level 1.
    - sync2=1 -> HELD.
    - else if cnt == DB_COUNT-1 -> IDLE.
    - else cnt <= cnt+1.
- Latency: number rising edges from the first edge sampling btn_in=1 as edge 1. db_pulse and db_level rise after edge DB_COUNT+3.
- Release latency is symmetric: db_level falls after edge DB_COUNT+3, counted from the first edge sampling btn_in=0.
- Bounce handling:
  - Any return of sync2 to the old value before the count completes restarts qualification from IDLE or HELD respectively.
  - No pulse is issued.
  - A held button never re-pulses.
- key_valid and key_code are registered from the current-cycle db_pulse vector, so they appear 1 cycle after db_pulse.
  - Priority when several bits pulse in the same cycle: center > up > down > left > right.
  - Lower-priority simultaneous pulses are dropped from key_code but remain visible on db_pulse.
  - key_code holds its last value while key_valid=0.
- any_held is combinational OR of db_level.
- Counters never wrap. The compare at DB_COUNT-1 terminates counting.
- Reset mid-operation: all state is cleared immediately. If a button is still held at deassertion, it is re-qualified from IDLE and produces one new pulse DB_COUNT+3 edges later.
- DB_COUNT=1: minimum legal value; the pulse comes 4 edges after the press.
- No enable input; the block runs continuously.

Test Plan:
- Clean press: DB_COUNT=4, raise btn_in[3] and hold for 20 cycles.
  - db_pulse[3] is high for exactly 1 cycle after edge 7; db_level[3] rises at the same edge.
  - key_valid=1 with key_code=3 on the next cycle.
  - No further pulses during the hold.
- Bounce rejection: DB_COUNT=4, toggle btn_in[0] with high runs of 3 cycles and low runs of 2 cycles, 5 times, then hold high.
  - Zero pulses during the bounce.
  - Exactly 1 pulse, 7 edges after the final rising sample.
- Release debounce: from HELD, drop btn_in[2] for 2 cycles, restore for 5 cycles, then drop permanently.
  - db_level[2] stays 1 through the glitch.
  - db_level[2] falls 7 edges after the final drop.
  - No pulse on the re-press glitch.
- Simultaneous press: raise btn_in[4] and btn_in[1] on the same edge.
  - db_pulse=5'b10010 for one cycle.
  - key_valid=1, key_code=4 next cycle.
- Reset mid-hold: assert rst asynchronously between edges while btn_in[1] is in HELD.
  - All outputs are 0 immediately.
  - After deassertion with btn_in[1] still high, one new db_pulse[1] arrives 7 edges later.
- Repeated presses: 3 clean presses of btn_in[0], each 10 cycles high and 10 cycles low.
  - Exactly 3 db_pulse[0] pulses and 3 key_valid events with key_code=0.
